// File: rtl/freq_pulse_gen.sv
// freq_pulse_gen: converts a requested frequency in Hz into a period in clock
// ticks using a 32-step restoring divider, then drives a square wave at it.
// A new period requested while running is held as pending and takes effect
// only at a period boundary, so the waveform never glitches mid-period.
//
// Handshake: a request is taken on any rising edge where freq_valid and
// freq_ready are both 1; freq_valid while freq_ready is 0 is dropped, never
// queued, and the requester need not hold freq_set after the accepting edge.
module freq_pulse_gen #(
    parameter int unsigned CLK_FREQ = 20000000,
    parameter int unsigned FREQ_MAX = 300000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] freq_set,
    input  logic        freq_valid,
    output logic        freq_ready,
    output logic        freq_err,
    output logic        running,
    output logic [31:0] period_out,
    output logic        pulse_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DIV     = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_RUN_DIV = 2'd3;

    logic [1:0]  state_q,    state_d;
    logic [31:0] dvs_q,      dvs_d;       // divisor (requested frequency)
    logic [31:0] dvd_q,      dvd_d;       // dividend, shifted out MSB first
    logic [63:0] rem_q,      rem_d;       // working remainder, wide to avoid overflow
    logic [31:0] quo_q,      quo_d;
    logic [4:0]  iter_q,     iter_d;
    logic [31:0] period_q,   period_d;    // active period, 0 when stopped
    logic [31:0] pend_q,     pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] cnt_q,      cnt_d;
    logic        pulse_q,    pulse_d;
    logic        err_q,      err_d;

    logic        accept;
    logic        div_active;
    logic        div_done;
    logic        gen;
    logic        boundary;
    logic [63:0] rem_shift;
    logic        rem_ge;
    logic [63:0] rem_next;
    logic [31:0] quo_next;

    assign freq_ready = (state_q == S_IDLE) || (state_q == S_RUN);
    assign accept     = freq_valid && freq_ready;
    assign div_active = (state_q == S_DIV) || (state_q == S_RUN_DIV);
    assign div_done   = div_active && (iter_q == 5'd31);
    assign gen        = (state_q == S_RUN) || (state_q == S_RUN_DIV);
    assign boundary   = gen && (cnt_q == period_q - 32'd1);

    // One restoring-divider step: bring down the next dividend bit and
    // subtract the divisor when it fits.
    always_comb begin
        rem_shift = {rem_q[62:0], dvd_q[31]};
        rem_ge    = (rem_shift >= {32'd0, dvs_q});
        rem_next  = rem_ge ? (rem_shift - {32'd0, dvs_q}) : rem_shift;
        quo_next  = {quo_q[30:0], rem_ge};
    end

    // Next-state logic: waveform advance, divider step, then request handling.
    always_comb begin
        state_d    = state_q;
        dvs_d      = dvs_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        iter_d     = iter_q;
        period_d   = period_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;

        if (gen) begin
            if (boundary) begin
                cnt_d = 32'd0;
                // A quotient finishing on the boundary itself is the newest
                // request and supersedes anything older that is pending.
                if (div_done) begin
                    period_d   = quo_next;
                    pend_vld_d = 1'b0;
                end else if (pend_vld_q) begin
                    period_d   = pend_q;
                    pend_vld_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 32'd1;
                if (div_done) begin
                    pend_d     = quo_next;
                    pend_vld_d = 1'b1;
                end
            end
        end

        if (div_active) begin
            rem_d  = rem_next;
            quo_d  = quo_next;
            dvd_d  = {dvd_q[30:0], 1'b0};
            iter_d = iter_q + 5'd1;
            if (div_done) begin
                state_d = S_RUN;
                if (state_q == S_DIV) begin
                    period_d = quo_next;
                    cnt_d    = 32'd0;
                end
            end
        end

        if (accept) begin
            if (freq_set > FREQ_MAX) begin
                err_d = 1'b1;
            end else if (freq_set == 32'd0) begin
                state_d    = S_IDLE;
                cnt_d      = 32'd0;
                period_d   = 32'd0;
                pend_vld_d = 1'b0;
            end else begin
                state_d = (state_q == S_IDLE) ? S_DIV : S_RUN_DIV;
                dvs_d   = freq_set;
                dvd_d   = 32'(CLK_FREQ);
                rem_d   = 64'd0;
                quo_d   = 32'd0;
                iter_d  = 5'd0;
            end
        end

        if ((state_d == S_RUN) || (state_d == S_RUN_DIV)) begin
            pulse_d = (cnt_d < (period_d >> 1));
        end else begin
            pulse_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dvs_q      <= 32'd0;
            dvd_q      <= 32'd0;
            rem_q      <= 64'd0;
            quo_q      <= 32'd0;
            iter_q     <= 5'd0;
            period_q   <= 32'd0;
            pend_q     <= 32'd0;
            pend_vld_q <= 1'b0;
            cnt_q      <= 32'd0;
            pulse_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvs_q      <= dvs_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            iter_q     <= iter_d;
            period_q   <= period_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
            err_q      <= err_d;
        end
    end

    assign freq_err   = err_q;
    assign running    = gen;
    assign period_out = period_q;
    assign pulse_out  = pulse_q;

endmodule

// File: tb/tb_freq_pulse_gen.sv
// Directed bench for freq_pulse_gen: start-up latency, duty cycle at several
// frequencies, rejection, mid-run retune, pending overwrite, stop and reset abort.
module tb_freq_pulse_gen;

    logic        clk;
    logic        rst_n;
    logic [31:0] freq_set;
    logic        freq_valid;
    logic        freq_ready;
    logic        freq_err;
    logic        running;
    logic [31:0] period_out;
    logic        pulse_out;

    int tests_run = 0;
    int tests_failed = 0;

    freq_pulse_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .freq_set   (freq_set),
        .freq_valid (freq_valid),
        .freq_ready (freq_ready),
        .freq_err   (freq_err),
        .running    (running),
        .period_out (period_out),
        .pulse_out  (pulse_out)
    );

    // Clock: 20 MHz
    initial clk = 1'b0;
    always #25 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge.
    task automatic do_accept(input logic [31:0] f);
        freq_set   = f;
        freq_valid = 1'b1;
        step();
        freq_valid = 1'b0;
    endtask

    // Count one high phase then one low phase; ends at the next first-high sample.
    task automatic measure(input int exp_hi, input int exp_lo, input bit align, input string name);
        int hi;
        int lo;
        int guard;
        hi = 0;
        lo = 0;
        guard = 0;
        if (align) begin
            while (pulse_out !== 1'b0 && guard < 5000) begin step(); guard++; end
            while (pulse_out !== 1'b1 && guard < 5000) begin step(); guard++; end
        end
        while (pulse_out === 1'b1 && hi < 5000) begin hi++; step(); end
        while (pulse_out === 1'b0 && lo < 5000) begin lo++; step(); end
        tests_run++;
        if (hi !== exp_hi) begin
            tests_failed++;
            $display("FAIL %s high_ticks: got %0d expected %0d", name, hi, exp_hi);
        end
        tests_run++;
        if (lo !== exp_lo) begin
            tests_failed++;
            $display("FAIL %s low_ticks: got %0d expected %0d", name, lo, exp_lo);
        end
    endtask

    // Start from IDLE and check the 32-cycle divide latency and first period.
    task automatic start_and_check(input logic [31:0] f, input logic [31:0] p, input string name);
        int nlow;
        nlow = 0;
        do_accept(f);                       // now at T0+1
        for (int i = 0; i < 32; i++) begin
            if (freq_ready === 1'b0 && running === 1'b0) nlow++;
            if (i < 31) step();
        end
        tests_run++;
        if (nlow !== 32) begin
            tests_failed++;
            $display("FAIL %s busy_cycles: got %0d expected 32", name, nlow);
        end
        step();                             // T0+33
        tests_run++;
        if ({freq_ready, running, pulse_out} !== 3'b111) begin
            tests_failed++;
            $display("FAIL %s start_flags: got ready/run/pulse=%b expected 111", name,
                     {freq_ready, running, pulse_out});
        end
        tests_run++;
        if (period_out !== p) begin
            tests_failed++;
            $display("FAIL %s period_out: got %0d expected %0d", name, period_out, p);
        end
    endtask

    task automatic stop_gen();
        do_accept(32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests_run++;
        if ({freq_ready, freq_err, running, pulse_out} !== 4'b1000 || period_out !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got rdy/err/run/pulse=%b period=%0d expected 1000 period=0",
                     {freq_ready, freq_err, running, pulse_out}, period_out);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_start_10k();
        start_and_check(32'd10000, 32'd2000, "start_10k");
        measure(1000, 1000, 1'b0, "start_10k");
    endtask

    task automatic test_160k();
        stop_gen();
        start_and_check(32'd160000, 32'd125, "f160k");
        measure(62, 63, 1'b0, "f160k");
        measure(62, 63, 1'b0, "f160k_2nd");
    endtask

    task automatic test_max_and_reject();
        stop_gen();
        start_and_check(32'd300000, 32'd66, "f300k");
        measure(33, 33, 1'b0, "f300k");
        do_accept(32'd300001);
        tests_run++;
        if (freq_err !== 1'b1 || freq_ready !== 1'b1 || period_out !== 32'd66 || running !== 1'b1) begin
            tests_failed++;
            $display("FAIL reject_pulse: got err=%b rdy=%b period=%0d run=%b expected err=1 rdy=1 period=66 run=1",
                     freq_err, freq_ready, period_out, running);
        end
        step();
        tests_run++;
        if (freq_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reject_one_cycle: got err=%b expected 0", freq_err);
        end
        measure(33, 33, 1'b1, "after_reject");
    endtask

    task automatic test_retune();
        stop_gen();
        start_and_check(32'd10000, 32'd2000, "retune_start");   // cnt = 0 here
        for (int i = 0; i < 500; i++) step();                  // cnt = 500
        do_accept(32'd20000);                                  // cnt = 501
        for (int i = 0; i < 1498; i++) step();                 // cnt = 1999
        tests_run++;
        if (period_out !== 32'd2000 || pulse_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL retune_before_boundary: got period=%0d pulse=%b expected 2000 0",
                     period_out, pulse_out);
        end
        step();                                                // new period, cnt = 0
        tests_run++;
        if (period_out !== 32'd1000 || pulse_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL retune_at_boundary: got period=%0d pulse=%b expected 1000 1",
                     period_out, pulse_out);
        end
        measure(500, 500, 1'b0, "retune_20k");
    endtask

    task automatic test_back_to_back();
        int guard;
        stop_gen();
        start_and_check(32'd10000, 32'd2000, "b2b_start");
        do_accept(32'd20000);
        for (int i = 0; i < 32; i++) step();
        do_accept(32'd40000);
        guard = 0;
        while (period_out === 32'd2000 && guard < 4000) begin step(); guard++; end
        tests_run++;
        if (period_out !== 32'd500) begin
            tests_failed++;
            $display("FAIL b2b_overwrite: got period=%0d expected 500", period_out);
        end
        measure(250, 250, 1'b0, "b2b_40k");
    endtask

    task automatic test_zero();
        tests_run++;
        if (pulse_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_precondition: got pulse=%b expected 1", pulse_out);
        end
        do_accept(32'd0);
        tests_run++;
        if ({pulse_out, running, freq_ready} !== 3'b001 || period_out !== 32'd0) begin
            tests_failed++;
            $display("FAIL zero_stop: got pulse/run/rdy=%b period=%0d expected 001 period=0",
                     {pulse_out, running, freq_ready}, period_out);
        end
        start_and_check(32'd50000, 32'd400, "restart_50k");
        measure(200, 200, 1'b0, "restart_50k");
    endtask

    task automatic test_ignore_busy();
        int errs;
        int guard;
        stop_gen();
        do_accept(32'd20000);
        for (int i = 0; i < 4; i++) step();
        freq_set   = 32'd300001;
        freq_valid = 1'b1;
        step();
        freq_valid = 1'b0;
        tests_run++;
        if (freq_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ignored_err: got err=%b expected 0", freq_err);
        end
        guard = 0;
        while (freq_ready !== 1'b1 && guard < 100) begin step(); guard++; end
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            if (freq_err !== 1'b0 || period_out !== 32'd1000 || freq_ready !== 1'b1) errs++;
            step();
        end
        tests_run++;
        if (errs !== 0) begin
            tests_failed++;
            $display("FAIL busy_not_queued: got %0d bad cycles expected 0", errs);
        end
    endtask

    task automatic test_reset_abort();
        stop_gen();
        do_accept(32'd10000);                 // T0+1
        for (int i = 0; i < 9; i++) step();   // T0+10
        rst_n = 1'b0;
        step();
        tests_run++;
        if ({freq_ready, freq_err, running, pulse_out} !== 4'b1000 || period_out !== 32'd0) begin
            tests_failed++;
            $display("FAIL abort_reset_values: got rdy/err/run/pulse=%b period=%0d expected 1000 period=0",
                     {freq_ready, freq_err, running, pulse_out}, period_out);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step();
        tests_run++;
        if (running !== 1'b0 || period_out !== 32'd0) begin
            tests_failed++;
            $display("FAIL abort_no_partial: got run=%b period=%0d expected 0 0", running, period_out);
        end
        start_and_check(32'd10000, 32'd2000, "after_abort");
        measure(1000, 1000, 1'b0, "after_abort");
    endtask

    initial begin
        rst_n      = 1'b0;
        freq_set   = 32'd0;
        freq_valid = 1'b0;
        #1;
        test_reset();
        test_start_10k();
        test_160k();
        test_max_and_reject();
        test_retune();
        test_zero();
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
